// File: rtl/alu_divider.sv
// Radix-2 restoring divider: W quotient bits in W cycles, with a one-cycle DONE state.
// Define ALU_DIVIDER_SIGNED_EN to add the sgn input for two's-complement operands.
module alu_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
`ifdef ALU_DIVIDER_SIGNED_EN
  input  logic         sgn,
`endif
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state, w_state_next;
  logic [CW-1:0]  r_count;
  logic [W-1:0]   r_dvd;        // dividend shifts out the top, quotient bits shift in below
  logic [W-1:0]   r_dvs;
  logic [W-1:0]   r_part;
  logic           r_neg_q, r_neg_r;

  logic           w_neg_a, w_neg_b, w_last, w_borrow;
  logic [W-1:0]   w_mag_a, w_mag_b, w_dvd_next, w_part_next;
  logic [W:0]     w_shift, w_trial;

  function automatic logic [W-1:0] neg_if(input logic n, input logic [W-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

`ifdef ALU_DIVIDER_SIGNED_EN
  assign w_neg_a = sgn & dividend[W-1];
  assign w_neg_b = sgn & divisor[W-1];
`else
  assign w_neg_a = 1'b0;
  assign w_neg_b = 1'b0;
`endif

  assign w_mag_a = neg_if(w_neg_a, dividend);
  assign w_mag_b = neg_if(w_neg_b, divisor);

  // The shifted partial remainder is below twice the divisor, so bit W of the
  // (W+1)-bit difference is set exactly when the trial subtraction borrows.
  assign w_shift     = {r_part, r_dvd[W-1]};
  assign w_trial     = w_shift - {1'b0, r_dvs};
  assign w_borrow    = w_trial[W];
  assign w_part_next = w_borrow ? w_shift[W-1:0] : w_trial[W-1:0];
  assign w_dvd_next  = {r_dvd[W-2:0], ~w_borrow};
  assign w_last      = (r_count == CW'(W - 1));

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: next state gets its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_next = (divisor == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_last) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_part    <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && divisor == '0) begin
            quotient  <= '1;
            remainder <= dividend;
            dbz       <= 1'b1;
          end else if (start) begin
            r_dvd   <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_part  <= '0;
            r_count <= '0;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
          end
        end
        S_RUN: begin
          r_part  <= w_part_next;
          r_dvd   <= w_dvd_next;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            quotient  <= neg_if(r_neg_q, w_dvd_next);
            remainder <= neg_if(r_neg_r, w_part_next);
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a division; it is sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, W bits, the numerator, captured on the accepting edge.
REQ-006 The block SHALL have port divisor, input, W bits, the denominator, captured on the accepting edge.
REQ-007 The block SHALL have port quotient, output, W bits, held from DONE until the next accepted start.
REQ-008 The block SHALL have port remainder, output, W bits, held like quotient.
REQ-009 The block SHALL have port busy, output, 1 bit, high in the RUN and DONE states.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse in the DONE state.
REQ-011 The block SHALL have port dbz, output, 1 bit, the divide-by-zero flag for the last result, held like quotient.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-013 The IDLE state SHALL move to RUN on an edge where start=1 and divisor!=0, loading the operands, clearing the partial remainder and setting count=0.
REQ-014 The IDLE state SHALL move directly to DONE on an edge where start=1 and divisor==0, setting quotient=all-ones, remainder=dividend and dbz=1.
REQ-015 The RUN state SHALL perform one radix-2 restoring step per cycle: shift the dividend MSB into the (W+1)-bit partial remainder; trial-subtract the divisor; if there is no borrow, keep the difference and shift in a quotient bit of 1, else restore and shift in 0.
REQ-016 The RUN state SHALL move to DONE on the edge that completes step W (count==W-1); W steps are performed exactly.
REQ-017 The DONE state SHALL last exactly one cycle with done=1, then move to IDLE unconditionally.
REQ-018 The latency SHALL be: start sampled at edge N with nonzero divisor gives done high in the cycle after edge N+W (W+1 cycles); divisor zero gives done in the cycle after edge N.
REQ-019 A start in RUN or DONE SHALL be ignored, and it SHALL NOT be queued.
REQ-020 The quotient, remainder and dbz outputs SHALL change only on entry to DONE and SHALL be stable at all other times.
REQ-021 On a normal completion, dbz SHALL be cleared.
REQ-022 A dividend less than the divisor SHALL give quotient=0 and remainder=dividend.

Reset
REQ-023 When rst=1 at an edge, the block SHALL force state=IDLE, count=0, quotient=0, remainder=0, busy=0, done=0 and dbz=0, from any state including mid-RUN.
REQ-024 Reset SHALL take priority over start on the same edge, and the aborted operation SHALL produce no done pulse.

Configuration
REQ-025 When the macro ALU_DIVIDER_SIGNED_EN is defined, the block SHALL add input port sgn (1 bit, sampled with start); with sgn=1 the operands are two's complement.
REQ-026 With sgn=1, the block SHALL divide the magnitudes using the same W-step core, truncate the quotient toward zero, give the remainder the sign of the dividend, and keep the same latency.
REQ-027 With sgn=1, a most-negative dividend divided by -1 SHALL give quotient=most-negative and remainder=0, with no extra flag.
REQ-028 With sgn=1 and divisor 0, the block SHALL apply the dbz rule of REQ-014 unchanged.
REQ-029 When ALU_DIVIDER_SIGNED_EN is not defined, the sgn port SHALL be absent and all operands SHALL be unsigned.

Verification
REQ-030 The bench SHALL check: W=16, dividend=100, divisor=7, start at edge N -> quotient=14, remainder=2, dbz=0, done high only in the cycle after edge N+16.
REQ-031 The bench SHALL check: dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0; and dividend=3, divisor=9 -> quotient=0, remainder=3.
REQ-032 The bench SHALL check: dividend=5, divisor=0 -> done in the cycle after the accepting edge, quotient=0xFFFF, remainder=5, dbz=1; a following 8/2 -> quotient=4, remainder=0, dbz=0.
REQ-033 The bench SHALL check: start pulsed with 50/5 during RUN of 100/7 -> the result is still 14 r 2, and there is exactly one done pulse.
REQ-034 The bench SHALL check: rst asserted 5 cycles into RUN -> all outputs 0 on the next cycle, no done pulse, and a new start of 9/3 -> quotient=3, remainder=0.
REQ-035 The bench SHALL check, with ALU_DIVIDER_SIGNED_EN and sgn=1: -7/2 -> quotient=0xFFFD, remainder=0xFFFF; and 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
